// File: rtl/odev2_tablo_tarayici.sv
// odev2_tablo_tarayici: steps a 3-in/2-out circuit through all 8 input combinations and captures its F/Q truth tables.
// Defining TABLO_KARSILASTIRMA_EN adds a row-by-row comparison against F_BEKLENEN/Q_BEKLENEN (hata, hata_sayisi).
module odev2_tablo_tarayici #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [7:0] F_BEKLENEN = 8'hFF,
  parameter logic [7:0] Q_BEKLENEN = 8'h55
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       basla,
  input  logic       f_in,
  input  logic       q_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       mesgul,
  output logic       bitti,
  output logic [7:0] f_tablo,
  output logic [7:0] q_tablo,
  output logic       hata,
  output logic [3:0] hata_sayisi
);
  typedef enum logic [1:0] {BOSTA, SUR, ORNEKLE, BITTI} state_t;
  state_t     r_state, w_next;
  logic [2:0] r_idx;
  logic [7:0] r_cnt, r_f_tablo, r_q_tablo;
  always_comb begin
    w_next = r_state;
    w_next = r_state == BOSTA   ? (basla ? SUR : BOSTA)
           : r_state == SUR     ? (r_cnt == 8'(SETTLE_CYC - 1) ? ORNEKLE : SUR)
           : r_state == ORNEKLE ? (r_idx == 3'd7 ? BITTI : SUR)
           : BOSTA;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= BOSTA;
      r_idx     <= 3'd0;
      r_cnt     <= 8'd0;
      r_f_tablo <= 8'd0;
      r_q_tablo <= 8'd0;
    end else begin
      r_state <= w_next;
      if (r_state == BOSTA && basla) begin
        r_idx     <= 3'd0;
        r_cnt     <= 8'd0;
        r_f_tablo <= 8'd0;
        r_q_tablo <= 8'd0;
      end
      if (r_state == SUR) r_cnt <= r_cnt + 8'd1;
      if (r_state == ORNEKLE) begin
        r_f_tablo[r_idx] <= f_in;
        r_q_tablo[r_idx] <= q_in;
        if (r_idx != 3'd7) begin
          r_idx <= r_idx + 3'd1;
          r_cnt <= 8'd0;
        end
      end
    end
  // Outputs decode registered state only; the index is masked outside the scan.
  assign mesgul = r_state == SUR || r_state == ORNEKLE;
  assign bitti = r_state == BITTI;
  assign {a_out, b_out, c_out} = mesgul ? r_idx : 3'd0;
  assign f_tablo = r_f_tablo;
  assign q_tablo = r_q_tablo;
`ifdef TABLO_KARSILASTIRMA_EN
  logic       r_hata, w_miss;
  logic [3:0] r_hata_sayisi;
  assign w_miss = f_in != F_BEKLENEN[r_idx] || q_in != Q_BEKLENEN[r_idx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_hata        <= 1'b0;
      r_hata_sayisi <= 4'd0;
    end else if (r_state == BOSTA && basla) begin
      r_hata        <= 1'b0;
      r_hata_sayisi <= 4'd0;
    end else if (r_state == ORNEKLE && w_miss) begin
      r_hata        <= 1'b1;
      r_hata_sayisi <= r_hata_sayisi + 4'd1;
    end
  assign hata = r_hata;
  assign hata_sayisi = r_hata_sayisi;
`else
  logic w_unused;
  assign w_unused = ^{F_BEKLENEN, Q_BEKLENEN};
  assign hata = 1'b0;
  assign hata_sayisi = 4'd0;
`endif
endmodule

// File: tb/tb_odev2_tablo_tarayici.sv
// tb_odev2_tablo_tarayici: three scanners (SETTLE_CYC 1, 2, 5) against a timeline model of the scan.
module tb_odev2_tablo_tarayici;
  logic clk = 0, rst_n = 0, basla = 0, flt = 0;
  always #5 clk = ~clk;
`ifdef TABLO_KARSILASTIRMA_EN
  localparam bit CMP = 1;
`else
  localparam bit CMP = 0;
`endif
  logic       a[3], b[3], c[3], mes[3], bt[3], h[3], fi[3], qi[3];
  logic [7:0] ft[3], qt[3], mf[3], mq[3];
  logic [3:0] hs[3];
  logic [7:0] fe = 8'hFF, qe = 8'h55;
  int n_chk = 0, n_pass = 0, cyc = 0, e_start = 0, b0 = 0;
  int mt[3], mhs[3], bc[3], bcnt[3];

  function automatic int per(int d);
    return d == 0 ? 2 : d == 1 ? 3 : 6;
  endfunction
  function automatic logic cut_f(int i, logic fl);
    return !(fl && i == 5);
  endfunction
  function automatic logic cut_q(int i, logic fl);
    return !i[0] ^ (fl && (i == 5 || i == 6));
  endfunction
  task automatic chk(string nm, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  odev2_tablo_tarayici #(.SETTLE_CYC(1)) u0 (.clk(clk), .rst_n(rst_n), .basla(basla), .f_in(fi[0]), .q_in(qi[0]),
    .a_out(a[0]), .b_out(b[0]), .c_out(c[0]), .mesgul(mes[0]), .bitti(bt[0]), .f_tablo(ft[0]), .q_tablo(qt[0]),
    .hata(h[0]), .hata_sayisi(hs[0]));
  odev2_tablo_tarayici u1 (.clk(clk), .rst_n(rst_n), .basla(basla), .f_in(fi[1]), .q_in(qi[1]),
    .a_out(a[1]), .b_out(b[1]), .c_out(c[1]), .mesgul(mes[1]), .bitti(bt[1]), .f_tablo(ft[1]), .q_tablo(qt[1]),
    .hata(h[1]), .hata_sayisi(hs[1]));
  odev2_tablo_tarayici #(.SETTLE_CYC(5)) u2 (.clk(clk), .rst_n(rst_n), .basla(basla), .f_in(fi[2]), .q_in(qi[2]),
    .a_out(a[2]), .b_out(b[2]), .c_out(c[2]), .mesgul(mes[2]), .bitti(bt[2]), .f_tablo(ft[2]), .q_tablo(qt[2]),
    .hata(h[2]), .hata_sayisi(hs[2]));

  // Circuit under test: F=1, Q=~C, with optional faults on rows 5 and 6.
  always_comb
    for (int d = 0; d < 3; d++) begin
      fi[d] = cut_f(int'({a[d], b[d], c[d]}), flt);
      qi[d] = cut_q(int'({a[d], b[d], c[d]}), flt);
    end

  always @(posedge clk) cyc++;

  // Model: mt = cycle number within the current scan (0 = idle); row r is sampled at the end of cycle (r+1)*p.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        mt[d] = 0; mf[d] = 0; mq[d] = 0; mhs[d] = 0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        int p, r;
        p = per(d);
        if (mt[d] == 0) begin
          if (basla) begin
            mt[d] = 1; mf[d] = 0; mq[d] = 0; mhs[d] = 0;
          end
        end else begin
          if (mt[d] % p == 0) begin
            r = mt[d] / p - 1;
            mf[d][r] = cut_f(r, flt);
            mq[d][r] = cut_q(r, flt);
            if (mf[d][r] != fe[r] || mq[d][r] != qe[r]) mhs[d]++;
          end
          mt[d] = (mt[d] == 8 * p + 1) ? 0 : mt[d] + 1;
        end
      end
    end

  always @(negedge clk)
    if (rst_n)
      for (int d = 0; d < 3; d++) begin
        int p, t;
        logic busy;
        logic [2:0] ea;
        logic [25:0] got, exp;
        p = per(d);
        t = mt[d];
        busy = t >= 1 && t <= 8 * p;
        ea = busy ? 3'((t - 1) / p) : 3'd0;
        exp = {ea, busy, t == 8 * p + 1, mf[d], mq[d], CMP && mhs[d] != 0, CMP ? 4'(mhs[d]) : 4'd0};
        got = {a[d], b[d], c[d], mes[d], bt[d], ft[d], qt[d], h[d], hs[d]};
        chk($sformatf("model d%0d cyc%0d", d, cyc), int'(got), int'(exp));
        if (bt[d]) begin
          bc[d] = cyc - e_start + 1;
          bcnt[d]++;
        end
      end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_mes", int'(mes[1]), 0);
    chk("rst_abc", int'({a[1], b[1], c[1]}), 0);
    chk("rst_ft", int'(ft[1]), 0);
    rst_n = 1;
    // Reset mid-scan at cycle 10
    @(negedge clk); basla = 1; e_start = cyc + 1;
    @(negedge clk); basla = 0;
    repeat (9) @(negedge clk);
    chk("mid_mes", int'(mes[1]), 1);
    chk("mid_abc", int'({a[1], b[1], c[1]}), 3);
    chk("mid_ft", int'(ft[1]), 8'h07);
    chk("mid_qt", int'(qt[1]), 8'h05);
    #2 rst_n = 0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("arst_out d%0d", d), int'({a[d], b[d], c[d], mes[d], bt[d], h[d], hs[d]}), 0);
      chk($sformatf("arst_tab d%0d", d), int'({ft[d], qt[d]}), 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (30) @(negedge clk);
    chk("no_bitti_after_rst", bcnt[1], 0);
    // Nominal scan
    @(negedge clk); basla = 1; e_start = cyc + 1;
    @(negedge clk); basla = 0;
    repeat (60) @(negedge clk);
    chk("bitti_cyc_s1", bc[0], 17);
    chk("bitti_cyc_s2", bc[1], 25);
    chk("bitti_cyc_s5", bc[2], 49);
    chk("bitti_once", bcnt[1], 1);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("nom_ft d%0d", d), int'(ft[d]), 8'hFF);
      chk($sformatf("nom_qt d%0d", d), int'(qt[d]), 8'h55);
    end
    chk("nom_hata", int'(h[1]), 0);
    chk("nom_hs", int'(hs[1]), 0);
    // Fault injection on rows 5 and 6
    flt = 1;
    @(negedge clk); basla = 1; e_start = cyc + 1;
    @(negedge clk); basla = 0;
    repeat (60) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("flt_ft d%0d", d), int'(ft[d]), 8'hDF);
      chk($sformatf("flt_qt d%0d", d), int'(qt[d]), 8'h35);
    end
    chk("flt_hata", int'(h[1]), CMP ? 1 : 0);
    chk("flt_hs", int'(hs[1]), CMP ? 2 : 0);
    chk("flt_bitti_cyc", bc[1], 25);
    flt = 0;
    // basla held through the bitti cycle, dropped before the first restart opportunity
    b0 = bcnt[1];
    basla = 1; e_start = cyc + 1;
    repeat (26) @(negedge clk);
    basla = 0;
    chk("held_mes", int'(mes[1]), 0);
    repeat (5) @(negedge clk);
    chk("held_one_bitti", bcnt[1] - b0, 1);
    repeat (60) @(negedge clk);
    // basla held one cycle longer: restart right after bitti
    b0 = bcnt[1];
    basla = 1; e_start = cyc + 1;
    repeat (27) @(negedge clk);
    basla = 0;
    chk("restart_mes", int'(mes[1]), 1);
    chk("restart_abc", int'({a[1], b[1], c[1]}), 0);
    repeat (60) @(negedge clk);
    chk("restart_two_bitti", bcnt[1] - b0, 2);
    chk("restart_ft", int'(ft[1]), 8'hFF);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
